// File: rtl/execute_pkg.sv
// rtl/execute_pkg.sv - shared pipeline constants and the ID/EX register layout
package execute_pkg;

    // ALU operation encodings carried on ALUOp
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_MUL = 4'd6;

    // Multiplier FSM encodings
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int MUL_STEPS = 32;

    typedef struct packed {
        logic [31:0] pc4;
        logic [31:0] read_data1;
        logic [31:0] read_data2;
        logic [31:0] sign_ext;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        reg_dst;
        logic        alu_src;
        logic        branch;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
        logic        mem_to_reg;
        logic [3:0]  alu_op;
    } id_ex_t;

endpackage

// File: rtl/execute_mul_unit.sv
// rtl/execute_mul_unit.sv - 32-step shift-add multiplier (IDLE/BUSY/DONE)
// Ports: clk, rst_n; start_i loads a_i (multiplicand) and b_i (multiplier);
// abort_i returns to IDLE; busy_o/done_o reflect state; product_o is the low word.
module mul_unit
    import execute_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] product_o
);

    logic [1:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [32:0] sum;

    // Accumulator holds {partial product, remaining multiplier bits};
    // each step adds the multiplicand to the high half on the current LSB
    // and shifts the whole thing right by one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mcand_d = mcand_q;
        sum     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
        case (state_q)
            ST_BUSY: begin
                acc_d = {sum, acc_q[31:1]};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(MUL_STEPS - 1)) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (start_i) begin
                    state_d = ST_BUSY;
                    cnt_d   = 6'd0;
                    acc_d   = {32'd0, b_i};
                    mcand_d = a_i;
                end
            end
        endcase
        if (abort_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 6'd0;
            acc_q   <= 64'd0;
            mcand_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
        end
    end

    assign busy_o    = (state_q == ST_BUSY);
    assign done_o    = (state_q == ST_DONE);
    assign product_o = acc_q[31:0];

endmodule

// File: rtl/execute.sv
// rtl/execute.sv - EX stage: ID/EX register, ALU, branch target, multiply stall
// Ports: clk, rst_n; decoded operands/controls in (pc4, readData1/2, signExt,
// rt, rd, regDst, ALUSrc, branch_in, memRead, memWrite, regWrite, memToReg,
// ALUOp, flush); memory-stage results out; stall back to fetch/decode.
module execute
    import execute_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc4,
    input  logic [31:0] readData1,
    input  logic [31:0] readData2,
    input  logic [31:0] signExt,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic        regDst,
    input  logic        ALUSrc,
    input  logic        branch_in,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        regWrite,
    input  logic        memToReg,
    input  logic [3:0]  ALUOp,
    input  logic        flush,
    output logic [31:0] branchAddr,
    output logic        zero,
    output logic [31:0] ALUres,
    output logic [31:0] writeData,
    output logic [4:0]  rd_out,
    output logic        branch_out,
    output logic        memRead_out,
    output logic        memWrite_out,
    output logic        regWrite_out,
    output logic        memToReg_out,
    output logic        stall
);

    id_ex_t      idex_q, idex_d;
    logic        mul_busy, mul_done, load_en, mul_start;
    logic [31:0] mul_lo, op_b_in, op_b, alu_res;

    assign load_en   = !mul_busy && !flush;
    assign mul_start = load_en && (ALUOp == ALU_MUL);
    // The multiplier latches its operands on the capture edge, so it sees
    // the incoming operand-B mux rather than the registered one.
    assign op_b_in   = ALUSrc ? signExt : readData2;

    always_comb begin
        idex_d            = '0;
        idex_d.pc4        = pc4;
        idex_d.read_data1 = readData1;
        idex_d.read_data2 = readData2;
        idex_d.sign_ext   = signExt;
        idex_d.rt         = rt;
        idex_d.rd         = rd;
        idex_d.reg_dst    = regDst;
        idex_d.alu_src    = ALUSrc;
        idex_d.branch     = branch_in;
        idex_d.mem_read   = memRead;
        idex_d.mem_write  = memWrite;
        idex_d.reg_write  = regWrite;
        idex_d.mem_to_reg = memToReg;
        idex_d.alu_op     = ALUOp;
    end

    // Flush squashes the whole entry into a bubble; it overrides a stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= '0;
        end else if (flush) begin
            idex_q <= '0;
        end else if (load_en) begin
            idex_q <= idex_d;
        end
    end

    mul_unit u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (mul_start),
        .abort_i   (flush),
        .a_i       (readData1),
        .b_i       (op_b_in),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_lo)
    );

    assign op_b = idex_q.alu_src ? idex_q.sign_ext : idex_q.read_data2;

    always_comb begin
        alu_res = 32'd0;
        case (idex_q.alu_op)
            ALU_ADD: alu_res = idex_q.read_data1 + op_b;
            ALU_SUB: alu_res = idex_q.read_data1 - op_b;
            ALU_AND: alu_res = idex_q.read_data1 & op_b;
            ALU_OR:  alu_res = idex_q.read_data1 | op_b;
            ALU_SLT: alu_res = {31'd0, $signed(idex_q.read_data1) < $signed(op_b)};
            ALU_NOR: alu_res = ~(idex_q.read_data1 | op_b);
            ALU_MUL: alu_res = mul_done ? mul_lo : 32'd0;
            default: alu_res = 32'd0;
        endcase
    end

    assign stall        = mul_busy;
    assign ALUres       = alu_res;
    assign zero         = !mul_busy && (alu_res == 32'd0);
    assign branchAddr   = idex_q.pc4 + {idex_q.sign_ext[29:0], 2'b00};
    assign writeData    = idex_q.read_data2;
    assign rd_out       = idex_q.reg_dst ? idex_q.rd : idex_q.rt;

    // Controls are masked while multiplying so the memory stage sees bubbles.
    assign branch_out   = idex_q.branch     && !mul_busy;
    assign memRead_out  = idex_q.mem_read   && !mul_busy;
    assign memWrite_out = idex_q.mem_write  && !mul_busy;
    assign regWrite_out = idex_q.reg_write  && !mul_busy;
    assign memToReg_out = idex_q.mem_to_reg && !mul_busy;

endmodule

// File: tb/tb_execute.sv
// tb/tb_execute.sv - self-checking bench for execute
module tb_execute;
    import execute_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc4, readData1, readData2, signExt;
    logic [4:0]  rt, rd;
    logic        regDst, ALUSrc, branch_in, memRead, memWrite, regWrite, memToReg;
    logic [3:0]  ALUOp;
    logic        flush;
    logic [31:0] branchAddr, ALUres, writeData;
    logic        zero, stall;
    logic [4:0]  rd_out;
    logic        branch_out, memRead_out, memWrite_out, regWrite_out, memToReg_out;
    logic [4:0]  ctrl_out;

    always #5 clk = ~clk;

    assign ctrl_out = {branch_out, memRead_out, memWrite_out, regWrite_out, memToReg_out};

    execute dut (
        .clk(clk), .rst_n(rst_n), .pc4(pc4), .readData1(readData1), .readData2(readData2),
        .signExt(signExt), .rt(rt), .rd(rd), .regDst(regDst), .ALUSrc(ALUSrc),
        .branch_in(branch_in), .memRead(memRead), .memWrite(memWrite), .regWrite(regWrite),
        .memToReg(memToReg), .ALUOp(ALUOp), .flush(flush), .branchAddr(branchAddr),
        .zero(zero), .ALUres(ALUres), .writeData(writeData), .rd_out(rd_out),
        .branch_out(branch_out), .memRead_out(memRead_out), .memWrite_out(memWrite_out),
        .regWrite_out(regWrite_out), .memToReg_out(memToReg_out), .stall(stall)
    );

    // ctrl = {branch, memRead, memWrite, regWrite, memToReg}
    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, imm, pc4;
        logic        alusrc, regdst;
        logic [4:0]  rt, rd, ctrl;
        logic [31:0] exp_res;
        logic        exp_zero;
        logic [4:0]  exp_rd;
        logic [31:0] exp_baddr;
    } vec_t;

    typedef struct {
        logic [31:0] res, baddr, wdata;
        logic        zero;
        logic [4:0]  rd, ctrl;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[12];
    int   errors = 0;
    int   checks = 0;

    function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, b, imm, p4,
                                input logic alusrc, regdst, input logic [4:0] rtv, rdv, ctrl,
                                input logic [31:0] res, input logic z, input logic [4:0] erd,
                                input logic [31:0] baddr);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.imm = imm; v.pc4 = p4;
        v.alusrc = alusrc; v.regdst = regdst; v.rt = rtv; v.rd = rdv; v.ctrl = ctrl;
        v.exp_res = res; v.exp_zero = z; v.exp_rd = erd; v.exp_baddr = baddr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ALUOp = v.op; readData1 = v.a; readData2 = v.b; signExt = v.imm; pc4 = v.pc4;
        ALUSrc = v.alusrc; regDst = v.regdst; rt = v.rt; rd = v.rd;
        {branch_in, memRead, memWrite, regWrite, memToReg} = v.ctrl;
        flush = 1'b0;
    endtask

    task automatic push_vec(input vec_t v);
        exp_t e;
        e.res = v.exp_res; e.zero = v.exp_zero; e.rd = v.exp_rd;
        e.baddr = v.exp_baddr; e.wdata = v.b; e.ctrl = v.ctrl;
        sb.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty when output expected", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, " ALUres"}, ALUres, e.res);
            chk({tag, " zero"}, 32'(zero), 32'(e.zero));
            chk({tag, " rd_out"}, 32'(rd_out), 32'(e.rd));
            chk({tag, " branchAddr"}, branchAddr, e.baddr);
            chk({tag, " writeData"}, writeData, e.wdata);
            chk({tag, " ctrl"}, 32'(ctrl_out), 32'(e.ctrl));
            chk({tag, " stall"}, 32'(stall), 32'd0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " stall"}, 32'(stall), 32'd0);
        chk({tag, " ALUres"}, ALUres, 32'd0);
        chk({tag, " zero"}, 32'(zero), 32'd1);
        chk({tag, " ctrl"}, 32'(ctrl_out), 32'd0);
        chk({tag, " branchAddr"}, branchAddr, 32'd0);
        chk({tag, " writeData"}, writeData, 32'd0);
        chk({tag, " rd_out"}, 32'(rd_out), 32'd0);
    endtask

    function automatic vec_t mul_vec(input logic [31:0] a, b, input logic [4:0] ctrl,
                                     input logic [31:0] prod_lo);
        return mk(ALU_MUL, a, b, 32'd0, 32'd0, 1'b0, 1'b1, 5'd2, 5'd5, ctrl,
                  prod_lo, prod_lo == 32'd0, 5'd5, 32'd0);
    endfunction

    task automatic run_mul(input string tag, input logic [31:0] a, b,
                           input logic [4:0] ctrl, input logic [31:0] prod_lo);
        vec_t v;
        int   n;
        int   bad;
        v = mul_vec(a, b, ctrl, prod_lo);
        drive(v);
        push_vec(v);
        @(posedge clk); #1;
        n = 0; bad = 0;
        while (stall === 1'b1 && n < 40) begin
            if (ctrl_out !== 5'd0 || zero !== 1'b0) bad++;
            n++;
            @(posedge clk); #1;
        end
        chk({tag, " busy_cycles"}, n, 32);
        chk({tag, " bubble_violations"}, bad, 0);
        check_out({tag, " done"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        tbl[0]  = mk(ALU_ADD, 32'd5, 32'd7, 32'h10, 32'h4, 0, 1, 5'd9, 5'd3, 5'b00010,
                     32'd12, 0, 5'd3, 32'h44);
        tbl[1]  = mk(ALU_SUB, 32'd9, 32'd9, 32'hFFFFFFFF, 32'h100, 0, 0, 5'd4, 5'd7, 5'b10000,
                     32'd0, 1, 5'd4, 32'hFC);
        tbl[2]  = mk(ALU_SLT, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 0, 1, 5'd1, 5'd2, 5'b00011,
                     32'd1, 0, 5'd2, 32'd0);
        tbl[3]  = mk(ALU_SLT, 32'd1, 32'hFFFFFFFF, 32'd1, 32'h10, 0, 0, 5'd31, 5'd0, 5'b00000,
                     32'd0, 1, 5'd31, 32'h14);
        tbl[4]  = mk(ALU_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h2000, 32'h8000, 0, 1, 5'd5, 5'd6,
                     5'b01000, 32'h00F000F0, 0, 5'd6, 32'h10000);
        tbl[5]  = mk(ALU_OR, 32'hF0000000, 32'h0000000F, 32'h3FFFFFFF, 32'd0, 0, 0, 5'd8, 5'd9,
                     5'b00100, 32'hF000000F, 0, 5'd8, 32'hFFFFFFFC);
        tbl[6]  = mk(ALU_NOR, 32'd0, 32'd0, 32'd1, 32'hFFFFFFFC, 0, 1, 5'd10, 5'd11, 5'b11111,
                     32'hFFFFFFFF, 0, 5'd11, 32'd0);
        tbl[7]  = mk(ALU_ADD, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 0, 1, 5'd0, 5'd0, 5'b00000,
                     32'd1, 0, 5'd0, 32'd0);
        tbl[8]  = mk(ALU_SUB, 32'd0, 32'd1, 32'd2, 32'h20, 0, 0, 5'd12, 5'd13, 5'b00001,
                     32'hFFFFFFFF, 0, 5'd12, 32'h28);
        tbl[9]  = mk(ALU_ADD, 32'd100, 32'h55, 32'hFFFFFFF6, 32'h40, 1, 1, 5'd14, 5'd15,
                     5'b00010, 32'h5A, 0, 5'd15, 32'h18);
        tbl[10] = mk(4'd7, 32'd3, 32'd4, 32'd0, 32'd0, 0, 0, 5'd2, 5'd3, 5'b10101,
                     32'd0, 1, 5'd2, 32'd0);
        tbl[11] = mk(4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 0, 1, 5'd0, 5'd1, 5'b00000,
                     32'd0, 1, 5'd1, 32'd0);

        // Reset with busy inputs applied: outputs must still read as cleared.
        rst_n = 1'b0;
        drive(tbl[6]);
        #3;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        check_reset_outputs("reset_edge");
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            drive(tbl[i]);
            push_vec(tbl[i]);
            @(posedge clk); #1;
            check_out($sformatf("vec%0d", i));
        end

        // Flush outside a multiply squashes the controls.
        drive(tbl[6]);
        flush = 1'b1;
        @(posedge clk); #1;
        chk("flush ctrl", 32'(ctrl_out), 32'd0);
        chk("flush stall", 32'(stall), 32'd0);
        flush = 1'b0;

        // Multiply, then back-to-back multiply with a zero operand, then DONE->IDLE.
        run_mul("mul", 32'h00010000, 32'h00030003, 5'b00010, 32'h00030000);
        run_mul("mul_zero", 32'd0, 32'h00001234, 5'b01001, 32'd0);
        drive(tbl[0]);
        push_vec(tbl[0]);
        @(posedge clk); #1;
        check_out("after_mul");

        // Flush at BUSY step 10.
        v = mul_vec(32'd7, 32'd9, 5'b11111, 32'd63);
        drive(v);
        @(posedge clk); #1;
        repeat (10) @(posedge clk);
        #1;
        chk("flush_mul pre stall", 32'(stall), 32'd1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_mul stall", 32'(stall), 32'd0);
        chk("flush_mul ctrl", 32'(ctrl_out), 32'd0);
        drive(tbl[1]);
        push_vec(tbl[1]);
        @(posedge clk); #1;
        check_out("post_flush");

        // Reset at BUSY step 20, observed without a clock edge.
        v = mul_vec(32'h0000FFFF, 32'h0000FFFF, 5'b00010, 32'hFFFE0001);
        drive(v);
        @(posedge clk); #1;
        repeat (20) @(posedge clk);
        #1;
        chk("reset_mul pre stall", 32'(stall), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mul");
        @(negedge clk);
        rst_n = 1'b1;
        drive(tbl[3]);
        push_vec(tbl[3]);
        @(posedge clk); #1;
        check_out("post_reset");

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
